// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and fetch-state encoding for the instruction fetch unit.
// Imported by the top and by the fetch buffer.
package inst_fetch_unit_pkg;

    localparam int          DW         = 32;
    localparam int          AW         = 5;
    localparam logic        RESET_ON   = 1'b1;
    localparam logic        RESET_EDGE = 1'b1;
    localparam logic [31:0] ZERO       = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs for decode.
// The head reads as zero whenever the buffer is empty.
module fetch_buffer #(
    parameter int DW        = inst_fetch_unit_pkg::DW,
    parameter int BUF_DEPTH = 2,
    parameter int CW        = $clog2(BUF_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [DW-1:0] push_pc,
    input  logic [DW-1:0] push_inst,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head_pc,
    output logic [DW-1:0] head_inst
);
    import inst_fetch_unit_pkg::*;

    localparam int PW = $clog2(BUF_DEPTH);

    logic [DW-1:0] mem_pc   [BUF_DEPTH];
    logic [DW-1:0] mem_inst [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; the head mux hides stale contents while empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush) begin
            mem_pc[wr_ptr]   <= push_pc;
            mem_inst[wr_ptr] <= push_inst;
        end
    end

    assign count     = count_q;
    assign head_pc   = (count_q != '0) ? mem_pc[rd_ptr]   : DW'(ZERO);
    assign head_inst = (count_q != '0) ? mem_inst[rd_ptr] : DW'(ZERO);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: one word read per cycle into a small buffer,
// valid/stall handoff to decode, flush-and-restart on redirect.
module inst_fetch_unit #(
    parameter int          DW        = inst_fetch_unit_pkg::DW,
    parameter int          AW        = inst_fetch_unit_pkg::AW,
    parameter logic [DW-1:0] RESET_PC = '0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_en_o,
    input  logic [DW-1:0] mem_data_i,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          inst_valid_o,
    output logic [DW-1:0] inst_o,
    output logic [DW-1:0] inst_pc_o,
    output logic          fetch_err_o
);
    import inst_fetch_unit_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [DW-1:0] fpc_q;
    logic          inflight_q;
    logic          err_q;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          pop;
    logic          issue;
    logic          misaligned;

    assign inst_valid_o = (count != '0);
    assign pop          = inst_valid_o && !stall_i;
    assign misaligned   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    // The pop frees a slot this cycle, so it is credited before the compare.
    assign occupancy    = count + CW'(inflight_q) - CW'(pop);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (redirect_i) begin
            state_d = misaligned ? ST_HALT : ST_RUN;
        end else if (state_q == ST_RUN && !rst_i) begin
            issue = (occupancy < CW'(BUF_DEPTH));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            fpc_q      <= RESET_PC;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            err_q      <= misaligned;
            if (redirect_i && !misaligned) fpc_q <= redirect_pc_i;
            else if (issue)                fpc_q <= fpc_q + DW'(4);
        end
    end

    fetch_buffer #(
        .DW        (DW),
        .BUF_DEPTH (BUF_DEPTH),
        .CW        (CW)
    ) u_fetch_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (issue),
        .push_pc   (fpc_q),
        .push_inst (mem_data_i),
        .pop       (pop),
        .flush     (redirect_i),
        .count     (count),
        .head_pc   (inst_pc_o),
        .head_inst (inst_o)
    );

    assign mem_addr_o  = fpc_q[AW+1:2];
    assign mem_rd_en_o = issue;
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// randomized stall/redirect traffic against an in-order PC stream model.
module tb_inst_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  mem_addr_o;
    logic        mem_rd_en_o;
    logic [31:0] mem_data_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fetch_err_o;

    inst_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_addr_o    (mem_addr_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_data_i    (mem_data_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .fetch_err_o   (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] rom [32];

    always @(negedge clk_i) begin
        if (mem_rd_en_o) mem_data_i <= rom[mem_addr_o];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: the decode-side stream is the consecutive PCs from the
    // last restart point; the memory-side stream is the same sequence, ahead.
    logic [31:0] exp_pc    = '0;
    logic [31:0] exp_fetch = '0;
    logic        halted    = 1'b0;
    logic        err_exp   = 1'b0;
    logic        hold      = 1'b0;
    logic [31:0] hold_pc   = '0;
    logic [31:0] hold_inst = '0;
    int          since     = 0;

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        return rom[pc[6:2]];
    endfunction

    task automatic do_cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rel);
        @(posedge clk_i);
        #1;
        if (rel) rst_i = 1'b0;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        @(negedge clk_i);
        if (rd) since = 0;
        else if (since < 3) since++;
        chk("fetch_err", {31'b0, fetch_err_o}, {31'b0, err_exp});
        if (rd) begin
            chk("rd_en_in_redirect", {31'b0, mem_rd_en_o}, 32'd0);
        end else if (halted) begin
            chk("valid_in_halt", {31'b0, inst_valid_o}, 32'd0);
            chk("rd_en_in_halt", {31'b0, mem_rd_en_o}, 32'd0);
        end else begin
            if (since == 1) chk("valid_after_flush", {31'b0, inst_valid_o}, 32'd0);
            else            chk("valid_running", {31'b0, inst_valid_o}, 32'd1);
            if (since == 2) chk("first_pc", inst_pc_o, exp_pc);
            if (hold) begin
                chk("stall_hold_pc", inst_pc_o, hold_pc);
                chk("stall_hold_inst", inst_o, hold_inst);
            end
            if (inst_valid_o && !st) begin
                chk("pop_pc", inst_pc_o, exp_pc);
                chk("pop_inst", inst_o, rom_at(exp_pc));
                exp_pc += 32'd4;
            end
            if (mem_rd_en_o) begin
                chk("mem_addr", {27'b0, mem_addr_o}, {27'b0, exp_fetch[6:2]});
                exp_fetch += 32'd4;
            end
        end
        hold      = !rd && !halted && inst_valid_o && st;
        hold_pc   = inst_pc_o;
        hold_inst = inst_o;
        err_exp   = rd && (rpc[1:0] != 2'b00);
        if (rd) begin
            if (rpc[1:0] == 2'b00) begin
                halted    = 1'b0;
                exp_pc    = rpc;
                exp_fetch = rpc;
            end else begin
                halted = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_err", {31'b0, fetch_err_o}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
        chk("rst_addr", {27'b0, mem_addr_o}, 32'd0);
    endtask

    task automatic model_reset();
        halted = 1'b0; since = 0; exp_pc = '0; exp_fetch = '0;
        hold = 1'b0; err_exp = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk_i);
        #3;
        rst_i      = 1'b1;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        do_cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0]  = 32'h0000_2083;
        rom[1]  = 32'h0010_2103;
        rom[2]  = 32'h0020_2183;
        rom[31] = 32'h0000_0000;

        repeat (2) @(negedge clk_i);
        check_reset_outputs();
        model_reset();
        do_cycle(1'b0, 1'b0, '0, 1'b1);
        repeat (6) do_cycle(1'b0, 1'b0, '0, 1'b0);

        repeat (3) do_cycle(1'b1, 1'b0, '0, 1'b0);
        repeat (4) do_cycle(1'b0, 1'b0, '0, 1'b0);

        repeat (4) do_cycle(1'b1, 1'b0, '0, 1'b0);
        do_cycle(1'b1, 1'b1, 32'h10, 1'b0);
        repeat (4) do_cycle(1'b0, 1'b0, '0, 1'b0);

        do_cycle(1'b0, 1'b1, 32'h7C, 1'b0);
        repeat (4) do_cycle(1'b0, 1'b0, '0, 1'b0);

        do_cycle(1'b0, 1'b1, 32'h6, 1'b0);
        repeat (3) do_cycle(1'b0, 1'b0, '0, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h4, 1'b0);
        repeat (4) do_cycle(1'b0, 1'b0, '0, 1'b0);

        do_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        repeat (3) do_cycle(1'b0, 1'b0, '0, 1'b0);

        repeat (3) do_cycle(1'b0, 1'b0, '0, 1'b0);
        async_reset();
        repeat (4) do_cycle(1'b0, 1'b0, '0, 1'b0);

        for (int c = 0; c < 800; c++) begin
            logic        st;
            logic        rd;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 2) == 0);
            rd  = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            rpc = {$urandom_range(0, 40), 2'b00};
            case ($urandom_range(0, 7))
                0:       rpc = rpc | 32'($urandom_range(1, 3));
                1:       rpc = 32'hFFFF_FFF8;
                default: ;
            endcase
            do_cycle(st, rd, rpc, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
